sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the single 32-bit external SRAM port between two requesters: instruction fetch (IF) and the data memory stage (MEM).
- Arbitrates between them, sequences a fixed-wait-state SRAM access, and returns per-requester ready/data handshakes.
- Sits between the IF/MEM stages and the SRAM pins. Its ready outputs are the pipeline freeze sources.

Parameters:
WAIT_CYCLES, 5, cycles an access occupies the SRAM bus (legal 2..15)
ADDR_BASE, 1024, byte address mapped to SRAM word 0

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_req  in  1  IF read request; held until if_ready
if_addr  in  32  IF byte address
if_data  out  32  IF read data, valid when if_ready & if_req
if_ready  out  1  IF handshake / not-stalled
mem_read  in  1  MEM read request; held until mem_ready
mem_write  in  1  MEM write request; held until mem_ready
mem_addr  in  32  MEM byte address
mem_wdata  in  32  MEM write data
mem_rdata  out  32  MEM read data, valid when mem_ready & mem_read
mem_ready  out  1  MEM handshake / not-stalled
SRAM_DQ  inout  32  SRAM data bus
SRAM_ADDR  out  17  SRAM word address
SRAM_WE_N  out  1  SRAM write enable, active low

Behaviour:
- Reset values:
  - state=IDLE, owner=none
  - if_data=0, mem_rdata=0
  - SRAM_ADDR=0, SRAM_WE_N=1, SRAM_DQ=Z
  - if_ready=mem_ready=0 while rst is high
  - rst mid-access aborts immediately; next cycle is IDLE with no ready pulse.
- Address mapping: SRAM_ADDR = ((addr - ADDR_BASE) >> 2)[16:0].
  - Subtraction is modulo 2^32; bits [1:0] are ignored.
  - No range check.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Arbitrate with fixed priority: MEM (mem_read|mem_write) over IF (if_req).
  - On grant: latch owner, op, address, wdata; load counter with WAIT_CYCLES-1; go to ACCESS.
  - No request: stay in IDLE.
- ACCESS lasts exactly WAIT_CYCLES cycles.
  - SRAM_ADDR is driven from the latched address.
  - Write: SRAM_DQ driven with latched wdata for all ACCESS cycles. SRAM_WE_N=0 in the first WAIT_CYCLES-1 cycles and 1 in the last cycle (hold margin).
  - Read: SRAM_DQ=Z. SRAM_DQ is sampled into the owner's data register at the end of the last ACCESS cycle.
  - Counter reaches 0 -> DONE.
- DONE: one cycle. Owner's ready=1, data register stable. Next state is IDLE.
- Ready is combinational:
  - mem_ready = ~(mem_read|mem_write) | (DONE & owner==MEM)
  - if_ready = ~if_req | (DONE & owner==IF)
- Latency: request first seen in IDLE at cycle T -> ready at T+WAIT_CYCLES+1. Back-to-back accesses are spaced WAIT_CYCLES+2 cycles.
- Both mem_read and mem_write high: treated as a write.
- Requester inputs changing during ACCESS are ignored (latched copy is used).
- A request dropped before ready still completes; the ready pulse is simply unobserved.
- Read data registers hold their value until the next read completes for that owner.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: a 1-bit last-grant flag flips priority. After a MEM grant, IF wins the next contested IDLE arbitration, and vice versa. The flag resets to "last=IF", so MEM wins first.
- Undefined: strict MEM-over-IF priority; IF may starve while MEM requests back-to-back.

Decomposition:
- Shared package/defines:
  - state encoding (IDLE/ACCESS/DONE)
  - owner encoding (NONE/IF/MEM)
  - SRAM_ADDR_W=17, existing WORD=32
- One sub-module: sram_wait_timer.
  - 4-bit down-counter with load, load value, and zero flag.
  - Reused by any future SRAM-timed block.

Test Plan:
- MEM write mem_addr=1028, wdata=0xDEADBEEF at T (defaults) -> SRAM_ADDR=1 T+1..T+5; SRAM_WE_N=0 T+1..T+4, 1 at T+5; DQ=0xDEADBEEF T+1..T+5; mem_ready=1 only at T+6.
- MEM read 1028 with SRAM model returning 0xDEADBEEF -> mem_rdata=0xDEADBEEF, mem_ready at T+6, SRAM_DQ=Z throughout.
- if_req (if_addr=1024) and mem_read (mem_addr=1032) both at T -> MEM served first (ready T+6); IF granted T+7, SRAM_ADDR=0, if_ready T+13.
- Same contention with ARB_ROUND_ROBIN_EN and continuous MEM reads -> grants alternate MEM, IF, MEM; without the macro, IF never granted.
- rst asserted at T+3 of a write -> T+4 state IDLE, WE_N=1, DQ=Z, no ready pulse; re-issued write completes normally.
- No requests -> if_ready=mem_ready=1, WE_N=1, DQ=Z indefinitely.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter and its timer.
// Holds FSM and owner encodings, bus widths, the latched-grant record and the
// byte-address to SRAM-word-address mapping helper.
package sram_arbiter_pkg;

  localparam int WORD_W      = 32;
  localparam int SRAM_ADDR_W = 17;
  localparam int TIMER_W     = 4;

  // FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Owner of the access in flight
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_MEM  = 2'd2;

  // Everything captured at grant time; requester inputs are ignored afterwards.
  typedef struct packed {
    logic [1:0]             owner;
    logic                   wr;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [WORD_W-1:0]      wdata;
  } grant_t;

  // Offset is modulo 2^32 and unchecked: addresses below the base wrap to
  // the top of the SRAM. Byte-lane bits [1:0] are dropped.
  function automatic logic [SRAM_ADDR_W-1:0] sram_word_addr(
    input logic [WORD_W-1:0] addr,
    input logic [WORD_W-1:0] base
  );
    return SRAM_ADDR_W'((addr - base) >> 2);
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side bundle for the SRAM arbiter: IF fetch port and MEM port.
// master = pipeline stages (drive requests), slave = arbiter (drives ready/data).
// Requests are level-held until the matching ready is seen.
interface sram_arbiter_if;
  import sram_arbiter_pkg::*;

  logic              if_req;
  logic [WORD_W-1:0] if_addr;
  logic [WORD_W-1:0] if_data;
  logic              if_ready;

  logic              mem_read;
  logic              mem_write;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output if_req, if_addr, mem_read, mem_write, mem_addr, mem_wdata,
    input  if_data, if_ready, mem_rdata, mem_ready
  );

  modport slave (
    input  if_req, if_addr, mem_read, mem_write, mem_addr, mem_wdata,
    output if_data, if_ready, mem_rdata, mem_ready
  );

endinterface

// File: rtl/sram_wait_timer.sv
// Purpose: 4-bit wait-state down-counter with load and zero flag.
// Latency: i_load takes effect on the next cycle; o_zero is combinational from the count.
// Backpressure: none; counting stops at zero until reloaded.
// Ports: clk, rst (sync, active high), i_load/i_load_val (reload), i_dec (count
// enable), o_zero (count == 0).
module sram_wait_timer
  import sram_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [TIMER_W-1:0] i_load_val,
  input  logic               i_dec,
  output logic               o_zero
);

  logic [TIMER_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - TIMER_W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/sram_arbiter.sv
// Purpose: shares one 32-bit SRAM port between IF fetch and MEM, fixed wait-state access.
// Latency: request seen in IDLE at T -> ready at T+WAIT_CYCLES+1; back-to-back spacing WAIT_CYCLES+2.
// Backpressure: if_ready/mem_ready stay low (pipeline freeze) while a request is pending.
// Ports: clk, rst (sync, active high); bus (sram_arbiter_if.slave) carries the IF/MEM
// handshakes; SRAM_DQ (bidirectional data), SRAM_ADDR (word address), SRAM_WE_N.
// Build option: define ARB_ROUND_ROBIN_EN for alternating priority on contention;
// otherwise MEM always wins over IF.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = 5,   // 2..15
  parameter int ADDR_BASE   = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_arbiter_if.slave          bus,
  inout  wire  [WORD_W-1:0]      SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N
);

  logic [1:0]        r_state;
  grant_t            r_grant;
  logic [WORD_W-1:0] r_if_data;
  logic [WORD_W-1:0] r_mem_rdata;

  logic w_mem_req;
  logic w_if_req;
  logic w_grant_mem;
  logic w_grant_if;
  logic w_grant;
  logic w_timer_zero;
  logic w_done;
  logic w_dq_oe;

  assign w_mem_req = bus.mem_read | bus.mem_write;
  assign w_if_req  = bus.if_req;

`ifdef ARB_ROUND_ROBIN_EN
  // Set when MEM took the last grant; starts as "IF was last" so MEM wins first.
  logic r_last_mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_mem <= 1'b0;
    end else if ((r_state == ST_IDLE) && w_grant) begin
      r_last_mem <= w_grant_mem;
    end
  end

  // MEM loses only a contested arbitration right after its own grant.
  assign w_grant_mem = w_mem_req & ~(w_if_req & r_last_mem);
`else
  assign w_grant_mem = w_mem_req;
`endif

  assign w_grant_if = w_if_req & ~w_grant_mem;
  assign w_grant    = w_grant_mem | w_grant_if;

  // Loaded with WAIT_CYCLES-1 so ACCESS spans counts N-1..0, i.e. exactly WAIT_CYCLES cycles.
  sram_wait_timer u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_load    ((r_state == ST_IDLE) && w_grant),
    .i_load_val(TIMER_W'(WAIT_CYCLES - 1)),
    .i_dec     (r_state == ST_ACCESS),
    .o_zero    (w_timer_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_if_data   <= '0;
      r_mem_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_grant.owner <= w_grant_mem ? OWN_MEM : OWN_IF;
            // read+write together is treated as a write
            r_grant.wr    <= w_grant_mem & bus.mem_write;
            r_grant.addr  <= sram_word_addr(w_grant_mem ? bus.mem_addr : bus.if_addr,
                                            WORD_W'(ADDR_BASE));
            r_grant.wdata <= bus.mem_wdata;
            r_state       <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (w_timer_zero) begin
            // Read data is taken at the end of the final wait cycle.
            if (!r_grant.wr) begin
              if (r_grant.owner == OWN_MEM) begin
                r_mem_rdata <= SRAM_DQ;
              end else begin
                r_if_data <= SRAM_DQ;
              end
            end
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_grant.owner <= OWN_NONE;
          r_state       <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_done  = (r_state == ST_DONE);
  assign w_dq_oe = (r_state == ST_ACCESS) && r_grant.wr;

  // Write data is held for the whole access; WE_N releases one cycle early
  // so the data still meets hold time after the write strobe ends.
  assign SRAM_DQ   = w_dq_oe ? r_grant.wdata : {WORD_W{1'bz}};
  assign SRAM_WE_N = ~(w_dq_oe & ~w_timer_zero);
  assign SRAM_ADDR = r_grant.addr;

  // Idle requesters read as not-stalled; a pending one is released only in DONE.
  assign bus.mem_ready = ~rst & (~w_mem_req | (w_done && (r_grant.owner == OWN_MEM)));
  assign bus.if_ready  = ~rst & (~w_if_req  | (w_done && (r_grant.owner == OWN_IF)));
  assign bus.mem_rdata = r_mem_rdata;
  assign bus.if_data   = r_if_data;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter (WAIT_CYCLES=5, ADDR_BASE=1024).
// A cycle table covers reset, write, read, wrap-around addressing and idle;
// hand sequences cover contention, priority policy and reset mid-access.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam logic [31:0] PAT = 32'hA5A5A5A5;
  localparam logic [31:0] DB  = 32'hDEADBEEF;
  localparam logic [31:0] D2  = 32'h12345678;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        tb_drv;
  logic        tb_model;
  logic [31:0] tb_val;

  wire  [31:0] SRAM_DQ;
  logic [16:0] SRAM_ADDR;
  logic        SRAM_WE_N;

  sram_arbiter_if bus();

  // SRAM side: either a fixed value or an address-dependent read model.
  assign SRAM_DQ = tb_drv ? (tb_model ? (32'hCAFE0000 | {15'd0, SRAM_ADDR}) : tb_val)
                          : 32'bz;

  sram_arbiter #(.WAIT_CYCLES(5), .ADDR_BASE(1024)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .SRAM_DQ  (SRAM_DQ),
    .SRAM_ADDR(SRAM_ADDR),
    .SRAM_WE_N(SRAM_WE_N)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rst, ifq, ifa, mr, mw, ma, mwd, drv, dv;
    logic [31:0] e_ifr, e_memr, e_addr, e_we, e_dq, e_ifd, e_memd;
  } vec_t;

  function automatic vec_t v(
    input logic [31:0] rst_i, ifq, ifa, mr, mw, ma, mwd, drv, dv,
    input logic [31:0] e_ifr, e_memr, e_addr, e_we, e_dq, e_ifd, e_memd
  );
    vec_t t;
    t.rst = rst_i; t.ifq = ifq; t.ifa = ifa; t.mr = mr; t.mw = mw; t.ma = ma;
    t.mwd = mwd; t.drv = drv; t.dv = dv; t.e_ifr = e_ifr; t.e_memr = e_memr;
    t.e_addr = e_addr; t.e_we = e_we; t.e_dq = e_dq; t.e_ifd = e_ifd; t.e_memd = e_memd;
    return t;
  endfunction

  task automatic clear_inputs();
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
    tb_drv = 1'b1; tb_model = 1'b0; tb_val = PAT;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  vec_t tbl[$];

  initial begin
    int          mem_done, if_done;
    logic [31:0] a1, a8, mem_d, if_d;
    int          seq[$];
    int          exp_seq[3];

    clear_inputs();
    rst = 1'b1;
    @(posedge clk); #1;

    // ---------------- cycle table ----------------
    tbl.push_back(v(1, 0,0, 0,0,0,0, 1,PAT,  0,0,0,1,PAT, 0,0));
    for (int i = 0; i < 2; i++)
      tbl.push_back(v(0, 0,0, 0,0,0,0, 1,PAT,  1,1,0,1,PAT, 0,0));
    // MEM write 1028 <- DEADBEEF; inputs scrambled mid-access must be ignored
    tbl.push_back(v(0, 0,0, 0,1,1028,DB, 1,PAT,  1,0,0,1,PAT, 0,0));
    tbl.push_back(v(0, 0,0, 0,1,1028,DB, 0,0,    1,0,1,0,DB,  0,0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(v(0, 0,0, 0,1,2048,0, 0,0,   1,0,1,0,DB,  0,0));
    tbl.push_back(v(0, 0,0, 0,1,1028,DB, 0,0,    1,0,1,1,DB,  0,0));
    tbl.push_back(v(0, 0,0, 0,1,1028,DB, 1,PAT,  1,1,1,1,PAT, 0,0));
    tbl.push_back(v(0, 0,0, 0,0,0,0, 1,PAT,      1,1,1,1,PAT, 0,0));
    // MEM read 1028, SRAM returns DEADBEEF; DUT must never drive DQ
    for (int i = 0; i < 6; i++)
      tbl.push_back(v(0, 0,0, 1,0,1028,0, 1,DB,  1,0,1,1,DB,  0,0));
    tbl.push_back(v(0, 0,0, 1,0,1028,0, 1,DB,    1,1,1,1,DB,  0,DB));
    tbl.push_back(v(0, 0,0, 0,0,0,0, 1,PAT,      1,1,1,1,PAT, 0,DB));
    // IF read at 1023: below base and misaligned -> word 0x1FFFF
    tbl.push_back(v(0, 1,1023, 0,0,0,0, 1,D2,    0,1,1,1,D2,  0,DB));
    for (int i = 0; i < 5; i++)
      tbl.push_back(v(0, 1,1023, 0,0,0,0, 1,D2,  0,1,32'h1FFFF,1,D2, 0,DB));
    tbl.push_back(v(0, 1,1023, 0,0,0,0, 1,D2,    1,1,32'h1FFFF,1,D2, D2,DB));
    for (int i = 0; i < 3; i++)
      tbl.push_back(v(0, 0,0, 0,0,0,0, 1,PAT,    1,1,32'h1FFFF,1,PAT, D2,DB));

    for (int i = 0; i < tbl.size(); i++) begin
      rst           = tbl[i].rst[0];
      bus.if_req    = tbl[i].ifq[0];
      bus.if_addr   = tbl[i].ifa;
      bus.mem_read  = tbl[i].mr[0];
      bus.mem_write = tbl[i].mw[0];
      bus.mem_addr  = tbl[i].ma;
      bus.mem_wdata = tbl[i].mwd;
      tb_drv        = tbl[i].drv[0];
      tb_val        = tbl[i].dv;
      @(negedge clk);
      check($sformatf("row%0d if_ready", i),  32'(bus.if_ready),  tbl[i].e_ifr);
      check($sformatf("row%0d mem_ready", i), 32'(bus.mem_ready), tbl[i].e_memr);
      check($sformatf("row%0d sram_addr", i), 32'(SRAM_ADDR),     tbl[i].e_addr);
      check($sformatf("row%0d we_n", i),      32'(SRAM_WE_N),     tbl[i].e_we);
      check($sformatf("row%0d dq", i),        SRAM_DQ,            tbl[i].e_dq);
      check($sformatf("row%0d if_data", i),   bus.if_data,        tbl[i].e_ifd);
      check($sformatf("row%0d mem_rdata", i), bus.mem_rdata,      tbl[i].e_memd);
      @(posedge clk); #1;
    end

    // ---------------- contention: MEM first, then IF ----------------
    do_reset();
    tb_model = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 1024;
    bus.mem_read = 1'b1; bus.mem_addr = 1032;
    mem_done = -1; if_done = -1; a1 = '1; a8 = '1; mem_d = '0; if_d = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 1) a1 = 32'(SRAM_ADDR);
      if (c == 8) a8 = 32'(SRAM_ADDR);
      if (bus.mem_read && bus.mem_ready && mem_done < 0) begin
        mem_done = c; mem_d = bus.mem_rdata;
      end
      if (bus.if_req && bus.if_ready && if_done < 0) begin
        if_done = c; if_d = bus.if_data;
      end
      @(posedge clk); #1;
      if (mem_done >= 0) bus.mem_read = 1'b0;
      if (if_done >= 0)  bus.if_req   = 1'b0;
    end
    check("contend mem_ready cycle", 32'(mem_done), 6);
    check("contend if_ready cycle",  32'(if_done),  13);
    check("contend mem sram_addr",   a1, 2);
    check("contend if sram_addr",    a8, 0);
    check("contend mem_rdata",       mem_d, 32'hCAFE0002);
    check("contend if_data",         if_d,  32'hCAFE0000);

    // ---------------- priority policy under continuous MEM reads ----------------
    do_reset();
    tb_model = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 1024;
    bus.mem_read = 1'b1; bus.mem_addr = 1032;
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq = '{2, 1, 2};
`else
    exp_seq = '{2, 2, 2};
`endif
    for (int c = 0; c < 40 && seq.size() < 3; c++) begin
      @(negedge clk);
      if (bus.mem_ready) seq.push_back(2);
      if (bus.if_req && bus.if_ready) seq.push_back(1);
      @(posedge clk); #1;
      if (seq.size() > 0 && seq[seq.size()-1] == 1) bus.if_req = 1'b0;
    end
    check("policy grant count", 32'(seq.size()), 3);
    for (int i = 0; i < 3 && i < seq.size(); i++)
      check($sformatf("policy grant%0d owner", i), 32'(seq[i]), 32'(exp_seq[i]));

    // ---------------- reset in the middle of a write ----------------
    do_reset();
    tb_drv = 1'b0;
    bus.mem_write = 1'b1; bus.mem_addr = 1028; bus.mem_wdata = 32'h55AA55AA;
    mem_done = -1;
    for (int c = 0; c < 20; c++) begin
      rst    = (c == 3);
      tb_drv = (c == 4);
      @(negedge clk);
      if (c == 3) check("abort ready in rst", 32'(bus.mem_ready), 0);
      if (c == 4) begin
        check("abort state idle", 32'(dut.r_state), 32'(ST_IDLE));
        check("abort we_n",       32'(SRAM_WE_N),   1);
        check("abort dq released", SRAM_DQ,         PAT);
      end
      if (c == 5) begin
        check("reissue we_n",      32'(SRAM_WE_N), 0);
        check("reissue sram_addr", 32'(SRAM_ADDR), 1);
        check("reissue dq",        SRAM_DQ,        32'h55AA55AA);
      end
      if (bus.mem_write && bus.mem_ready && mem_done < 0) mem_done = c;
      @(posedge clk); #1;
      if (mem_done >= 0) bus.mem_write = 1'b0;
    end
    rst = 1'b0;
    check("reissue mem_ready cycle", 32'(mem_done), 10);

    // ---------------- quiet bus ----------------
    clear_inputs();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("quiet%0d ready", c), {30'd0, bus.if_ready, bus.mem_ready}, 3);
      check($sformatf("quiet%0d we_n", c),  32'(SRAM_WE_N), 1);
      check($sformatf("quiet%0d dq", c),    SRAM_DQ, PAT);
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
